// File: rtl/halflife_button_cond.sv
// Up/down push-button conditioner: 2-flop sync, debounce, press detect and
// hold-to-auto-repeat, with up/down conflict blocking. Channel 0 = up, 1 = down.
module halflife_button_cond #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic up_raw,
  input  logic down_raw,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_level,
  output logic down_level,
  output logic conflict
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DLY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST = TMR_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_e;

  logic [1:0]       raw_s;
  logic [1:0]       meta_q;
  logic [1:0]       sync_q;
  logic [1:0]       level_q, level_d;
  logic [1:0]       prev_q;
  logic [1:0]       press_s;
  logic [1:0]       pulse_q, pulse_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [TMR_W-1:0] tmr_q [2];
  logic [TMR_W-1:0] tmr_d [2];
  state_e           state_q [2];
  state_e           state_d [2];

  assign raw_s   = {down_raw, up_raw};
  assign press_s = level_q & ~prev_q;

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      level_d[ch] = level_q[ch];
      cnt_d[ch]   = '0;
      if (sync_q[ch] != level_q[ch]) begin
        if (cnt_q[ch] == DB_LAST) begin
          level_d[ch] = ~level_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
        end
      end else begin
        cnt_d[ch] = '0;
      end
    end
    conflict_d = level_d[0] & level_d[1];
  end

  // Repeat FSMs; conflict forces both back to idle so a held button needs a re-press.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      tmr_d[ch]   = tmr_q[ch];
      pulse_d[ch] = 1'b0;
      case (state_q[ch])
        S_IDLE: begin
          tmr_d[ch] = '0;
          if (press_s[ch]) begin
            pulse_d[ch] = 1'b1;
            state_d[ch] = S_DELAY;
          end else begin
            state_d[ch] = S_IDLE;
          end
        end
        S_DELAY: begin
          if (!level_q[ch]) begin
            state_d[ch] = S_IDLE;
            tmr_d[ch]   = '0;
          end else if (tmr_q[ch] == DLY_LAST) begin
            pulse_d[ch] = 1'b1;
            tmr_d[ch]   = '0;
            state_d[ch] = S_REPEAT;
          end else begin
            tmr_d[ch] = tmr_q[ch] + TMR_W'(1);
          end
        end
        S_REPEAT: begin
          if (!level_q[ch]) begin
            state_d[ch] = S_IDLE;
            tmr_d[ch]   = '0;
          end else if (tmr_q[ch] == RATE_LAST) begin
            pulse_d[ch] = 1'b1;
            tmr_d[ch]   = '0;
          end else begin
            tmr_d[ch] = tmr_q[ch] + TMR_W'(1);
          end
        end
        default: begin
          state_d[ch] = S_IDLE;
          tmr_d[ch]   = '0;
        end
      endcase
      if (conflict_q) begin
        state_d[ch] = S_IDLE;
        tmr_d[ch]   = '0;
        pulse_d[ch] = 1'b0;
      end else begin
        pulse_d[ch] = pulse_d[ch];
      end
    end
    // Defensive: the core must never see both step requests at once.
    if (pulse_d[0]) begin
      pulse_d[1] = 1'b0;
    end else begin
      pulse_d[1] = pulse_d[1];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q     <= 2'b00;
      sync_q     <= 2'b00;
      level_q    <= 2'b00;
      prev_q     <= 2'b00;
      pulse_q    <= 2'b00;
      conflict_q <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        cnt_q[ch]   <= '0;
        tmr_q[ch]   <= '0;
        state_q[ch] <= S_IDLE;
      end
    end else begin
      meta_q     <= raw_s;
      sync_q     <= meta_q;
      level_q    <= level_d;
      prev_q     <= level_q;
      pulse_q    <= pulse_d;
      conflict_q <= conflict_d;
      for (int ch = 0; ch < 2; ch++) begin
        cnt_q[ch]   <= cnt_d[ch];
        tmr_q[ch]   <= tmr_d[ch];
        state_q[ch] <= state_d[ch];
      end
    end
  end

  assign up_pulse   = pulse_q[0];
  assign down_pulse = pulse_q[1];
  assign up_level   = level_q[0];
  assign down_level = level_q[1];
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_halflife_button_cond.sv
// Bench for halflife_button_cond: table of single-button holds plus hand-written
// conflict / simultaneous / reset-mid-repeat sequences; pulses checked via scoreboard queues.
module tb_halflife_button_cond;

  localparam int D  = 16;
  localparam int RD = 64;
  localparam int RR = 16;
  localparam int FAR = 1 << 30;

  logic clk = 1'b0;
  logic reset, up_raw, down_raw;
  logic up_pulse, down_pulse, up_level, down_level, conflict;

  halflife_button_cond #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .up_raw(up_raw), .down_raw(down_raw),
    .up_pulse(up_pulse), .down_pulse(down_pulse),
    .up_level(up_level), .down_level(down_level), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int exp_up[$];
  int exp_dn[$];
  int up_cnt = 0;
  int dn_cnt = 0;
  bit mon_en = 1'b0;

  typedef struct {
    string name;
    bit    is_up;
    int    hold;
    int    exp_pulses;
  } vec_t;
  vec_t tbl[7];

  int         chk_c[4];
  logic [2:0] chk_e[4];

  // Scoreboard: every cycle each pulse output must match whether its queue head is due now.
  always @(negedge clk) begin : mon
    logic e_up, e_dn;
    if (mon_en) begin
      e_up = 1'b0;
      e_dn = 1'b0;
      if (exp_up.size() > 0) e_up = (exp_up[0] == cyc);
      if (exp_dn.size() > 0) e_dn = (exp_dn[0] == cyc);
      if (e_up) void'(exp_up.pop_front());
      if (e_dn) void'(exp_dn.pop_front());
      n_vec += 2;
      if (up_pulse !== e_up) begin
        n_err++;
        $display("FAIL up_pulse cyc=%0d got=%b exp=%b", cyc, up_pulse, e_up);
      end
      if (down_pulse !== e_dn) begin
        n_err++;
        $display("FAIL down_pulse cyc=%0d got=%b exp=%b", cyc, down_pulse, e_dn);
      end
      if (up_pulse === 1'b1) up_cnt++;
      if (down_pulse === 1'b1) dn_cnt++;
    end
  end

  task automatic chk(string nm, logic [4:0] got, logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [2:0] lmask(bit is_up, logic lv);
    return is_up ? {lv, 2'b00} : {1'b0, lv, 1'b0};
  endfunction

  task automatic push(bit is_up, int t);
    if (is_up) exp_up.push_back(t);
    else       exp_dn.push_back(t);
  endtask

  // Raw high on edges k..k+h-1: press pulse at k+D+2, repeats at +RD then every RR
  // while the level (which falls at edge k+h+D+1) is still high.
  task automatic push_hold(bit is_up, int k, int h, int lim);
    int p, fall;
    if (h >= D) begin
      p    = k + D + 2;
      fall = k + h + D + 1;
      if (p <= lim) push(is_up, p);
      for (int t = p + RD; t <= fall && t <= lim; t += RR) push(is_up, t);
    end
  endtask

  // Drive raw inputs for 'total' edges; level checks at the offsets in chk_c.
  task automatic run(int uon, int uoff, int don, int doff, int total, string nm);
    for (int i = 0; i < total; i++) begin
      up_raw   = (i >= uon) && (i < uoff);
      down_raw = (i >= don) && (i < doff);
      @(negedge clk);
      for (int j = 0; j < 4; j++)
        if (chk_c[j] == i)
          chk($sformatf("%s_lvl%0d", nm, j), {up_level, down_level, conflict, 2'b00},
              {chk_e[j], 2'b00});
    end
    up_raw   = 1'b0;
    down_raw = 1'b0;
  endtask

  initial begin
    int k, h, c0;
    logic lv;

    tbl[0] = '{"glitch15", 1'b1, 15, 0};
    tbl[1] = '{"up40",     1'b1, 40, 1};
    tbl[2] = '{"dn200",    1'b0, 200, 10};
    tbl[3] = '{"up16",     1'b1, 16, 1};
    tbl[4] = '{"dn15",     1'b0, 15, 0};
    tbl[5] = '{"up64",     1'b1, 64, 1};
    tbl[6] = '{"up65",     1'b1, 65, 2};

    reset = 1'b1;
    up_raw = 1'b0;
    down_raw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    chk("reset_state", {up_level, down_level, conflict, up_pulse, down_pulse}, 5'b00000);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_state", {up_level, down_level, conflict, up_pulse, down_pulse}, 5'b00000);

    for (int v = 0; v < 7; v++) begin
      k  = cyc + 1;
      h  = tbl[v].hold;
      lv = (h >= D);
      push_hold(tbl[v].is_up, k, h, FAR);
      chk_c[0] = D;     chk_e[0] = lmask(tbl[v].is_up, 1'b0);
      chk_c[1] = D + 1; chk_e[1] = lmask(tbl[v].is_up, lv);
      chk_c[2] = h + D; chk_e[2] = lmask(tbl[v].is_up, lv);
      chk_c[3] = h + D + 1; chk_e[3] = lmask(tbl[v].is_up, 1'b0);
      c0 = tbl[v].is_up ? up_cnt : dn_cnt;
      if (tbl[v].is_up) run(0, h, 0, 0, h + D + 20, tbl[v].name);
      else              run(0, 0, 0, h, h + D + 20, tbl[v].name);
      n_vec++;
      if ((tbl[v].is_up ? up_cnt : dn_cnt) - c0 != tbl[v].exp_pulses) begin
        n_err++;
        $display("FAIL %s_count got=%0d exp=%0d", tbl[v].name,
                 (tbl[v].is_up ? up_cnt : dn_cnt) - c0, tbl[v].exp_pulses);
      end
    end

    // Up held, down joins 30 cycles later: only the initial up press pulse.
    k = cyc + 1;
    exp_up.push_back(k + D + 2);
    chk_c[0] = 50;  chk_e[0] = 3'b111;
    chk_c[1] = 140; chk_e[1] = 3'b100;
    chk_c[2] = -1;  chk_e[2] = 3'b000;
    chk_c[3] = -1;  chk_e[3] = 3'b000;
    run(0, 200, 30, 120, 250, "conflict");

    // Both rise on the same edge: no pulse anywhere.
    chk_c[0] = 20;  chk_e[0] = 3'b111;
    chk_c[1] = 125; chk_e[1] = 3'b000;
    run(0, 100, 0, 100, 140, "simul");

    // Reset while in REPEAT with up held, then a fresh press and restarted schedule.
    k = cyc + 1;
    push_hold(1'b1, k, 1000, k + 118);
    up_raw = 1'b1;
    repeat (119) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid", {up_level, down_level, conflict, up_pulse, down_pulse}, 5'b00000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = cyc + 1;
    c0 = up_cnt;
    push_hold(1'b1, k, 150, FAR);
    repeat (150) @(negedge clk);
    up_raw = 1'b0;
    repeat (D + 30) @(negedge clk);
    n_vec++;
    if (up_cnt - c0 != 7) begin
      n_err++;
      $display("FAIL rst_mid_count got=%0d exp=%0d", up_cnt - c0, 7);
    end

    n_vec++;
    if (exp_up.size() != 0 || exp_dn.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected got=%0d exp=%0d", exp_up.size() + exp_dn.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
